// File: rtl/cfg_lut6_2_loader_pkg.sv
// rtl/cfg_lut6_2_loader_pkg.sv - shared sizes and FSM encoding for the reconfigurable LUT6_2
// Purpose: constants and state type shared by cfg_lut6_2_loader and lut6_2_lookup.
// Contents: CFG_BITS (truth-table width), CNT_W (shift counter width), state_t (IDLE/SHIFT).
package cfg_lut6_2_loader_pkg;

    localparam int CFG_BITS = 64;
    localparam int CNT_W    = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/lut6_2_lookup.sv
// rtl/lut6_2_lookup.sv - combinational O5/O6 mux over a 64-bit truth table
// Purpose: LUT6_2 read path, shared with the fixed-INIT LUT6_2 emulator.
// Ports:
//   cfg  in  64  truth table
//   addr in  6   lookup address, addr[5] is the MSB
//   o6   out 1   cfg[addr]
//   o5   out 1   cfg[addr[4:0]] (addr[5] ignored)
module lut6_2_lookup
    import cfg_lut6_2_loader_pkg::*;
(
    input  logic [CFG_BITS-1:0] cfg,
    input  logic [5:0]          addr,
    output logic                o6,
    output logic                o5
);

    assign o6 = cfg[addr];
    // O5 reads the lower half of the table only
    assign o5 = cfg[{1'b0, addr[4:0]}];

endmodule

// File: rtl/cfg_lut6_2_loader.sv
// rtl/cfg_lut6_2_loader.sv - LUT6_2 with run-time reloadable truth table
// Purpose: 64-bit truth-table register rewritten either by a parallel word that is
//          serialised one bit per clock, or by a CFGLUT5-style CE/CDI/CDO shift port.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   LD_DATA/VALID     parallel truth table and its valid
//   LD_READY          word can be accepted (IDLE)
//   BUSY              parallel load being shifted in
//   CFG_DONE          one-cycle pulse after the 64th shift of a parallel load
//   CE, CDI, CDO      external serial port; CDO = cfg[63]
//   I0..I5            lookup address, I5 is the MSB
//   O6, O5            combinational lookups of the live cfg
module cfg_lut6_2_loader
    import cfg_lut6_2_loader_pkg::*;
#(
    parameter logic [63:0] INIT = 64'h0000_0000_0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [63:0] LD_DATA,
    input  logic        LD_VALID,
    output logic        LD_READY,
    output logic        BUSY,
    output logic        CFG_DONE,
    input  logic        CE,
    input  logic        CDI,
    output logic        CDO,
    input  logic        I0,
    input  logic        I1,
    input  logic        I2,
    input  logic        I3,
    input  logic        I4,
    input  logic        I5,
    output logic        O6,
    output logic        O5
);

    state_t              state_q, state_d;
    logic [CFG_BITS-1:0] cfg_q, cfg_d;
    logic [CFG_BITS-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cfg_q   <= INIT;
            hold_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        LD_READY = 1'b0;
        BUSY     = 1'b0;
        case (state_q)
            IDLE: begin
                LD_READY = 1'b1;
                // A parallel load takes priority over the external shift port
                if (LD_VALID) begin
                    hold_d  = LD_DATA;
                    cnt_d   = CNT_W'(CFG_BITS - 1);
                    state_d = SHIFT;
                end else if (CE) begin
                    cfg_d = {cfg_q[CFG_BITS-2:0], CDI};
                end
            end
            SHIFT: begin
                BUSY   = 1'b1;
                cfg_d  = {cfg_q[CFG_BITS-2:0], hold_q[CFG_BITS-1]};
                hold_d = {hold_q[CFG_BITS-2:0], 1'b0};
                if (cnt_q == '0) begin
                    // 64th shift: leave cnt parked at zero instead of wrapping
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign CFG_DONE = done_q;
    assign CDO      = cfg_q[CFG_BITS-1];

    lut6_2_lookup u_lookup (
        .cfg  (cfg_q),
        .addr ({I5, I4, I3, I2, I1, I0}),
        .o6   (O6),
        .o5   (O5)
    );

endmodule

// File: tb/tb_cfg_lut6_2_loader.sv
// tb/tb_cfg_lut6_2_loader.sv - self-checking bench for cfg_lut6_2_loader
`timescale 1ns/1ps
module tb_cfg_lut6_2_loader;

    localparam logic [63:0] INIT_V = 64'hFEDC_BA98_7654_3210;

    logic        CLK = 1'b0;
    logic        RST;
    logic [63:0] LD_DATA;
    logic        LD_VALID;
    logic        LD_READY, BUSY, CFG_DONE;
    logic        CE, CDI, CDO;
    logic [5:0]  addr;
    logic        O6, O5;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [63:0] model;

    cfg_lut6_2_loader #(.INIT(INIT_V)) dut (
        .CLK(CLK), .RST(RST),
        .LD_DATA(LD_DATA), .LD_VALID(LD_VALID), .LD_READY(LD_READY),
        .BUSY(BUSY), .CFG_DONE(CFG_DONE),
        .CE(CE), .CDI(CDI), .CDO(CDO),
        .I0(addr[0]), .I1(addr[1]), .I2(addr[2]), .I3(addr[3]), .I4(addr[4]), .I5(addr[5]),
        .O6(O6), .O5(O5)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0] a;
        logic       o6;
        logic       o5;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reads the whole table through the lookup port well inside one clock phase
    task automatic read_cfg(output logic [63:0] v6, output logic [63:0] v5);
        for (int i = 0; i < 64; i++) begin
            addr = 6'(i);
            #0.01;
            v6[i] = O6;
            v5[i] = O5;
        end
    endtask

    task automatic check_table(input string name, input logic [63:0] exp);
        logic [63:0] v6, v5;
        read_cfg(v6, v5);
        check({name, "_o6"}, v6, exp);
        check({name, "_o5"}, v5, {exp[31:0], exp[31:0]});
    endtask

    // Called right after the accept edge; counts BUSY samples until CFG_DONE
    task automatic wait_done(output int busy_n, output bit seen);
        busy_n = 0;
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            if (CFG_DONE) begin
                seen = 1;
                break;
            end
            if (BUSY) busy_n++;
            tick();
        end
    endtask

    task automatic do_load(input logic [63:0] w, input bit noise, input string name);
        int n;
        bit seen;
        LD_VALID = 1'b1;
        LD_DATA = w;
        tick();
        LD_VALID = 1'b0;
        LD_DATA = {$urandom, $urandom};
        if (noise) begin
            CE = 1'b1;
            CDI = 1'($urandom);
        end
        n = 0;
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            if (CFG_DONE) begin
                seen = 1;
                break;
            end
            tick();
            n++;
            if (noise) begin
                CDI = 1'($urandom);
                LD_VALID = 1'($urandom);
            end
        end
        CE = 1'b0;
        LD_VALID = 1'b0;
        check({name, "_done"}, 64'(seen), 64'd1);
        check({name, "_latency"}, 64'(n), 64'd64);
        model = w;
        check_table(name, model);
    endtask

    initial begin
        vec_t vt[6];
        logic [63:0] v6, v5, a_w, b_w, w;
        int n, ndone;
        int done_at[2];
        bit seen;

        vt[0] = '{6'd4,  1'b1, 1'b1};
        vt[1] = '{6'd5,  1'b0, 1'b0};
        vt[2] = '{6'd36, 1'b1, 1'b1};
        vt[3] = '{6'd63, 1'b1, 1'b0};
        vt[4] = '{6'd32, 1'b0, 1'b0};
        vt[5] = '{6'd0,  1'b0, 1'b0};

        RST = 1'b1; LD_DATA = '0; LD_VALID = 1'b0; CE = 1'b0; CDI = 1'b0; addr = '0;
        tick(); tick();
        RST = 1'b0;

        // Reset state
        model = INIT_V;
        check("rst_ld_ready", 64'(LD_READY), 64'd1);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_cfg_done", 64'(CFG_DONE), 64'd0);
        check("rst_cdo", 64'(CDO), 64'd1);
        for (int i = 0; i < 6; i++) begin
            addr = vt[i].a;
            #0.01;
            check($sformatf("vec_o6_%0d", vt[i].a), 64'(O6), 64'(vt[i].o6));
            check($sformatf("vec_o5_%0d", vt[i].a), 64'(O5), 64'(vt[i].o5));
        end
        check_table("rst_table", INIT_V);

        // Parallel load with detailed handshake checks
        LD_VALID = 1'b1;
        LD_DATA = 64'h8000_0000_0000_0001;
        tick();
        LD_VALID = 1'b0;
        check("ld_ready_drop", 64'(LD_READY), 64'd0);
        wait_done(n, seen);
        check("ld1_done", 64'(seen), 64'd1);
        check("ld1_busy_cycles", 64'(n), 64'd64);
        check("ld1_ready_at_done", 64'(LD_READY), 64'd1);
        tick();
        check("ld1_done_pulse", 64'(CFG_DONE), 64'd0);
        model = 64'h8000_0000_0000_0001;
        addr = 6'd0;  #0.01; check("ld1_o6_0", 64'(O6), 64'd1);
        addr = 6'd63; #0.01; check("ld1_o6_63", 64'(O6), 64'd1);
        addr = 6'd32; #0.01; check("ld1_o6_32", 64'(O6), 64'd0);
        check("ld1_o5_32", 64'(O5), 64'd1);

        // Back-to-back loads with LD_VALID held
        a_w = 64'hAAAA_AAAA_AAAA_AAAA;
        b_w = 64'h5555_5555_5555_5555;
        ndone = 0;
        done_at[0] = 0;
        done_at[1] = 0;
        LD_VALID = 1'b1;
        LD_DATA = a_w;
        tick();
        LD_DATA = b_w;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (CFG_DONE && ndone < 2) begin
                done_at[ndone] = c;
                ndone++;
            end
            if (ndone == 1 && c == done_at[0] + 1) LD_VALID = 1'b0;
        end
        LD_VALID = 1'b0;
        check("b2b_pulses", 64'(ndone), 64'd2);
        check("b2b_spacing", 64'(done_at[1] - done_at[0]), 64'd65);
        model = b_w;
        addr = 6'd0; #0.01; check("b2b_o6_0", 64'(O6), 64'd1);
        addr = 6'd1; #0.01; check("b2b_o6_1", 64'(O6), 64'd0);

        // Serial port from an all-zero table
        do_load(64'h0, 1'b0, "zero_load");
        CE = 1'b1;
        CDI = 1'b1;
        tick();
        CDI = 1'b0;
        for (int i = 0; i < 62; i++) tick();
        model = 64'h4000_0000_0000_0000;
        check_table("ser_63", model);
        check("ser_63_cdo", 64'(CDO), 64'd0);
        tick();
        CE = 1'b0;
        model = 64'h8000_0000_0000_0000;
        check("ser_64_cdo", 64'(CDO), 64'd1);
        check_table("ser_64", model);

        // CE and LD_VALID noise during SHIFT must not disturb the result
        do_load(64'h0123_4567_89AB_CDEF, 1'b1, "ce_in_shift");

        // LD_VALID and CE together in IDLE: load wins, no shift on the accept edge
        w = 64'hC3A5_0F96_1E2D_7B48;
        LD_VALID = 1'b1;
        CE = 1'b1;
        CDI = 1'b1;
        LD_DATA = w;
        tick();
        LD_VALID = 1'b0;
        CE = 1'b0;
        check_table("simul_accept", model);
        wait_done(n, seen);
        check("simul_done", 64'(seen), 64'd1);
        model = w;
        check_table("simul_final", model);

        // Reset after 30 shifts aborts the load
        w = 64'h0F0F_F0F0_1234_ABCD;
        LD_VALID = 1'b1;
        LD_DATA = w;
        tick();
        LD_VALID = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check_table("partial_30", {model[33:0], w[63:34]});
        check("partial_busy", 64'(BUSY), 64'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        model = INIT_V;
        check_table("abort_cfg", INIT_V);
        check("abort_busy", 64'(BUSY), 64'd0);
        check("abort_ready", 64'(LD_READY), 64'd1);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            if (CFG_DONE) seen = 1;
            tick();
        end
        check("abort_no_done", 64'(seen), 64'd0);

        // Randomised mix of parallel loads and serial shifts against the model
        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(1, 0) == 1) begin
                do_load({$urandom, $urandom}, 1'($urandom), $sformatf("rnd_load_%0d", it));
            end else begin
                n = $urandom_range(70, 1);
                for (int k = 0; k < n; k++) begin
                    CE = 1'($urandom);
                    CDI = 1'($urandom);
                    if (CE) model = {model[62:0], CDI};
                    tick();
                end
                CE = 1'b0;
                check_table($sformatf("rnd_ser_%0d", it), model);
                check($sformatf("rnd_cdo_%0d", it), 64'(CDO), 64'(model[63]));
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
